// File: rtl/iob_eth_mdio_pkg.sv
// Shared definitions for the clause-22 MDIO PHY responder: FSM states,
// opcodes, well-known register indices and preamble length.
package iob_eth_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST2   = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        RDATA = 3'd6,
        WDATA = 3'd7
    } mdio_state_e;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] BMCR   = 5'd0;
    localparam logic [4:0] BMSR   = 5'd1;
    localparam logic [4:0] PHYID1 = 5'd2;
    localparam logic [4:0] PHYID2 = 5'd3;

    localparam logic [5:0] PREAMBLE_LEN = 6'd32;

endpackage

// File: rtl/iob_eth_mdio_regs.sv
// 32x16 PHY register file: reset values, read-only ID registers, link status
// overlay on BMSR and BMCR bit-15 self-clearing soft reset.
module iob_eth_mdio_regs
    import iob_eth_mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1619,
    parameter logic [15:0] BMCR_RST = 16'h1140
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic        link_i,
    output logic [15:0] rdata_o
);

    logic [15:0] regs_r [32];
    logic        srst_s;
    logic        wr_ok_s;

    function automatic logic [15:0] reset_val(input logic [4:0] idx);
        case (idx)
            BMCR:    reset_val = BMCR_RST;
            PHYID1:  reset_val = PHY_ID1;
            PHYID2:  reset_val = PHY_ID2;
            default: reset_val = 16'h0000;
        endcase
    endfunction

    assign srst_s  = we_i && (waddr_i == BMCR) && wdata_i[15];
    assign wr_ok_s = we_i && (waddr_i != PHYID1) && (waddr_i != PHYID2);

    // storage; BMCR bit 15 is never stored so it reads back as 0
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= reset_val(5'(i));
        end else if (srst_s) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= reset_val(5'(i));
        end else if (wr_ok_s) begin
            regs_r[waddr_i] <= (waddr_i == BMCR) ? {1'b0, wdata_i[14:0]} : wdata_i;
        end
    end

    // read port with live link status in BMSR bit 2
    always_comb begin
        rdata_o = regs_r[raddr_i];
        if (raddr_i == BMSR) begin
            rdata_o[2] = link_i;
        end else begin
            rdata_o[2] = regs_r[raddr_i][2];
        end
    end

endmodule

// File: rtl/iob_sync.sv
// Two-flop synchroniser for signals crossing into the clk_i domain.
module iob_sync #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] signal_i,
    output logic [DATA_W-1:0] signal_o
);

    logic [DATA_W-1:0] meta_r;

    // metastability filter: two back-to-back flops
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            meta_r   <= RST_VAL;
            signal_o <= RST_VAL;
        end else begin
            meta_r   <= signal_i;
            signal_o <= meta_r;
        end
    end

endmodule

// File: rtl/iob_eth_mdio_phy.sv
// Clause-22 MDIO PHY responder: oversamples MDC/MDIO on clk_i, decodes
// frames addressed to PHY_ADDR and serves iob_eth_mdio_regs.
module iob_eth_mdio_phy
    import iob_eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1619,
    parameter logic [15:0] BMCR_RST = 16'h1140
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        link_i,
    output logic        reg_wr_o,
    output logic [4:0]  reg_wr_addr_o,
    output logic [15:0] reg_wr_data_o
);

    logic        mdc_sync_s, mdio_sync_s;
    logic        mdc_prev_r, rise_r;
    logic [15:0] rd_data_s;

    mdio_state_e state_r, state_s;
    logic [5:0]  pre_cnt_r, pre_cnt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic [1:0]  op_r, op_s;
    logic [4:0]  phyad_r, phyad_s;
    logic [4:0]  regad_r, regad_s;
    logic [15:0] shift_r, shift_s;
    logic        mdio_o_r, mdio_o_s;
    logic        mdio_oe_r, mdio_oe_s;
    logic        wr_r, wr_s;
    logic [4:0]  wr_addr_r, wr_addr_s;
    logic [15:0] wr_data_r, wr_data_s;

    iob_sync #(.DATA_W(2)) u_sync (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .signal_i ({mdc_i, mdio_i}),
        .signal_o ({mdc_sync_s, mdio_sync_s})
    );

    iob_eth_mdio_regs #(
        .PHY_ID1  (PHY_ID1),
        .PHY_ID2  (PHY_ID2),
        .BMCR_RST (BMCR_RST)
    ) u_regs (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .we_i     (wr_r),
        .waddr_i  (wr_addr_r),
        .wdata_i  (wr_data_r),
        .raddr_i  (regad_r),
        .link_i   (link_i),
        .rdata_o  (rd_data_s)
    );

    // MDC rising-edge detector; rise_r marks the bit-sampling cycle
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mdc_prev_r <= 1'b0;
            rise_r     <= 1'b0;
        end else begin
            mdc_prev_r <= mdc_sync_s;
            rise_r     <= mdc_sync_s & ~mdc_prev_r;
        end
    end

    // frame decoder: next state and next outputs, evaluated on MDC rises only
    always_comb begin
        state_s   = state_r;
        pre_cnt_s = pre_cnt_r;
        bit_cnt_s = bit_cnt_r;
        op_s      = op_r;
        phyad_s   = phyad_r;
        regad_s   = regad_r;
        shift_s   = shift_r;
        mdio_o_s  = mdio_o_r;
        mdio_oe_s = mdio_oe_r;
        wr_s      = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        if (rise_r) begin
            case (state_r)
                IDLE: begin
                    if (mdio_sync_s) begin
                        if (pre_cnt_r != PREAMBLE_LEN) begin
                            pre_cnt_s = pre_cnt_r + 6'd1;
                        end else begin
                            pre_cnt_s = pre_cnt_r;
                        end
                    end else if (pre_cnt_r == PREAMBLE_LEN) begin
                        state_s   = ST2;
                        pre_cnt_s = 6'd0;
                    end else begin
                        pre_cnt_s = 6'd0;
                    end
                end
                ST2: begin
                    bit_cnt_s = 4'd0;
                    if (mdio_sync_s) begin
                        state_s = OP;
                    end else begin
                        state_s = IDLE;
                    end
                end
                OP: begin
                    op_s = {op_r[0], mdio_sync_s};
                    if (bit_cnt_r == 4'd0) begin
                        bit_cnt_s = 4'd1;
                    end else if ((op_s == OP_RD) || (op_s == OP_WR)) begin
                        state_s   = PHYAD;
                        bit_cnt_s = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                PHYAD: begin
                    phyad_s = {phyad_r[3:0], mdio_sync_s};
                    if (bit_cnt_r != 4'd4) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else if (phyad_s == PHY_ADDR) begin
                        state_s   = REGAD;
                        bit_cnt_s = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                REGAD: begin
                    regad_s = {regad_r[3:0], mdio_sync_s};
                    if (bit_cnt_r != 4'd4) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else begin
                        state_s   = TA;
                        bit_cnt_s = 4'd0;
                    end
                end
                TA: begin
                    if (bit_cnt_r == 4'd0) begin
                        bit_cnt_s = 4'd1;
                        if (op_r == OP_RD) begin
                            mdio_oe_s = 1'b1;
                            mdio_o_s  = 1'b0;
                        end else begin
                            mdio_oe_s = 1'b0;
                        end
                    end else begin
                        bit_cnt_s = 4'd0;
                        if (op_r == OP_RD) begin
                            state_s  = RDATA;
                            mdio_o_s = rd_data_s[15];
                            shift_s  = {rd_data_s[14:0], 1'b0};
                        end else begin
                            state_s = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (bit_cnt_r == 4'd15) begin
                        state_s   = IDLE;
                        mdio_oe_s = 1'b0;
                        mdio_o_s  = 1'b0;
                        bit_cnt_s = 4'd0;
                    end else begin
                        mdio_o_s  = shift_r[15];
                        shift_s   = {shift_r[14:0], 1'b0};
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                WDATA: begin
                    shift_s = {shift_r[14:0], mdio_sync_s};
                    if (bit_cnt_r == 4'd15) begin
                        state_s   = IDLE;
                        bit_cnt_s = 4'd0;
                        wr_s      = 1'b1;
                        wr_addr_s = regad_r;
                        wr_data_s = shift_s;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    pre_cnt_s = 6'd0;
                    mdio_oe_s = 1'b0;
                    mdio_o_s  = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // frame decoder state and registered outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r   <= IDLE;
            pre_cnt_r <= 6'd0;
            bit_cnt_r <= 4'd0;
            op_r      <= 2'b00;
            phyad_r   <= 5'd0;
            regad_r   <= 5'd0;
            shift_r   <= 16'h0000;
            mdio_o_r  <= 1'b0;
            mdio_oe_r <= 1'b0;
            wr_r      <= 1'b0;
            wr_addr_r <= 5'd0;
            wr_data_r <= 16'h0000;
        end else begin
            state_r   <= state_s;
            pre_cnt_r <= pre_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            op_r      <= op_s;
            phyad_r   <= phyad_s;
            regad_r   <= regad_s;
            shift_r   <= shift_s;
            mdio_o_r  <= mdio_o_s;
            mdio_oe_r <= mdio_oe_s;
            wr_r      <= wr_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    assign mdio_o        = mdio_o_r;
    assign mdio_oe_o     = mdio_oe_r;
    assign reg_wr_o      = wr_r;
    assign reg_wr_addr_o = wr_addr_r;
    assign reg_wr_data_o = wr_data_r;

endmodule

// File: doc/iob_eth_mdio_phy.md
Name: iob_eth_mdio_phy

Overview:
- PHY-side MDIO management responder: the far end of the core's MIIM master (MIICOMMAND/MIIADDRESS/MIITX_DATA/MIIRX_DATA).
- Samples MDC/MDIO with the system clock, decodes IEEE 802.3 clause-22 frames, and serves a 32x16 PHY register file.
- Used as the emulated PHY in simulation and FPGA loopback builds, alongside the MII TX/RX path.

Parameters:
- PHY_ADDR, 5'd0: PHYAD this responder answers to.
- PHY_ID1, 16'h0022: reset and read-only value of reg 2.
- PHY_ID2, 16'h1619: reset and read-only value of reg 3.
- BMCR_RST, 16'h1140: reset value of reg 0.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- mdc_i  in  1  management clock from the MAC; asynchronous to clk_i.
- mdio_i  in  1  MDIO line as seen at the pad.
- mdio_o  out  1  MDIO drive value.
- mdio_oe_o  out  1  MDIO output enable; pad is tri-stated when 0.
- link_i  in  1  link status; appears in reg 1 bit 2.
- reg_wr_o  out  1  one-cycle pulse on every committed register write.
- reg_wr_addr_o  out  5  address of the committed write.
- reg_wr_data_o  out  16  data of the committed write.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, preamble count 0, register file at reset values.
  - Reg 0 = BMCR_RST, reg 2 = PHY_ID1, reg 3 = PHY_ID2, all other registers 0.
- Sync and edge detect:
  - mdc_i and mdio_i each pass through a 2-flop synchroniser.
  - An MDC rising edge ("rise") is detected one cycle after the synchroniser output goes high.
  - Bit sampling and output updates occur in the rise cycle.
  - Requirement on MDC: high and low phases each ≥3 clk_i cycles.
- Preamble (IDLE): a sampled 1 increments the count, saturating at 32; a sampled 0 clears it.
  - A 0 while count = 32 moves to ST2; the ST 01 first bit is consumed.
  - ST2: sampled 1 moves to OP; sampled 0 moves to IDLE with count cleared.
- OP (2 bits): 10 = read, 01 = write, 00/11 = return to IDLE.
- PHYAD (5 bits, MSB first): on mismatch with PHY_ADDR, go to IDLE with count 0 and never drive.
- REGAD (5 bits): latched into the address register.
- Read:
  - TA state: at the rise sampling the first TA bit, set mdio_oe_o=1 and mdio_o=0.
  - At the next rise, mdio_o = D15 of the addressed register, then D14..D0 on successive rises.
  - Register data is snapshotted into a 16-bit shift register at that rise.
  - At the rise following D0, mdio_oe_o=0 and the FSM returns to IDLE with count 0.
- Write:
  - TA: skip 2 bits without checking.
  - Shift 16 data bits MSB first.
  - On the 16th rise, commit the write and pulse reg_wr_o for one cycle with address and data; return to IDLE.
- Register rules:
  - Regs 2 and 3 are read-only; writes to them are dropped but still pulse reg_wr_o.
  - Reg 1 reads as {stored[15:3], link_i, stored[1:0]}; link_i is sampled at the snapshot rise.
  - Write to reg 0 with bit 15 = 1: the register file returns to reset values in the commit cycle, and bit 15 reads 0 thereafter (self-clearing).
- Reset mid-frame: outputs drop to 0 asynchronously and the frame is lost; no partial write is committed.
- mdio_oe_o is never asserted outside the read TA/data window.

Decomposition:
- Package iob_eth_mdio_pkg holds:
  - FSM state encodings: IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA.
  - Opcode constants: OP_RD=2'b10, OP_WR=2'b01.
  - Register indices: BMCR=0, BMSR=1, PHYID1=2, PHYID2=3.
  - PREAMBLE_LEN=32.
- Sub-module iob_eth_mdio_regs: register file with reset values, read-only handling, the link_i overlay and the reg 0 self-clear/soft reset.
- Synchronisers reuse iob_sync.

Test Plan:
- Preamble 32×1, read PHYAD=0 REGAD=2 -> mdio_oe_o rises at TA bit 1, TA bit 2 = 0, data 0x0022 MSB first, oe drops after D0.
- Write reg 4 = 0x01E1, then read reg 4 -> reg_wr_o pulses once with addr 4 / data 0x01E1; readback 0x01E1.
- Preamble of only 31 ones, then a read of reg 2 -> mdio_oe_o stays 0 for the whole frame.
- Read with PHYAD=3 while PHY_ADDR=0 -> no drive; a correct read immediately afterwards still returns 0x0022.
- Write reg 4 = 0x05E1, write reg 0 = 0x8000, read reg 0 and reg 4 -> 0x1140 (bit 15 clear) and 0x0000; link_i=1 then read reg 1 -> bit 2 = 1.
- Assert arst_n_i during read data bit D7 -> mdio_oe_o=0 immediately; the next full read frame returns correct data.
